// File: rtl/act_loader_pkg.sv
// act_loader_pkg: shared types and default widths for the activation loader.
//   state_t   - loader FSM states
//   IDLE_DATA - value driven on the write data bus when no word is valid
//   *_DEF     - default parameter values; DATA_W is two activation samples wide
package act_loader_pkg;

    localparam int unsigned ACTBUF_DATA_LEN = 16;
    localparam int unsigned DATA_W_DEF      = 2 * ACTBUF_DATA_LEN;
    localparam int unsigned ADDR_W_DEF      = 16;
    localparam int unsigned CNT_W_DEF       = 12;
    localparam int unsigned RD_LAT_DEF      = 2;

    localparam logic [DATA_W_DEF-1:0] IDLE_DATA = '1;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_REQ,
        ISSUE,
        DRAIN,
        WAIT_DONE
    } state_t;

endpackage

// File: rtl/act_loader_rdpipe.sv
// act_loader_rdpipe: tracks source reads in flight and registers returning data.
//   clk_l, rst_n : clock, synchronous active-low reset (clears reads in flight)
//   rd_en        : read strobe presented to the source memory
//   rd_data      : source data, valid RD_LAT cycles after rd_en
//   wr_vld       : registered valid, RD_LAT+1 cycles after rd_en
//   wr_data      : registered data, all-ones when wr_vld is low
module act_loader_rdpipe #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned RD_LAT = 2
) (
    input  logic              clk_l,
    input  logic              rst_n,
    input  logic              rd_en,
    input  logic [DATA_W-1:0] rd_data,
    output logic              wr_vld,
    output logic [DATA_W-1:0] wr_data
);

    // vld_sr[RD_LAT-1] marks the cycle in which rd_data carries a requested word
    logic [RD_LAT-1:0] vld_sr;

    always_ff @(posedge clk_l) begin
        if (!rst_n) begin
            vld_sr  <= '0;
            wr_vld  <= 1'b0;
            wr_data <= '1;
        end else begin
            vld_sr  <= RD_LAT'({vld_sr, rd_en});
            wr_vld  <= vld_sr[RD_LAT-1];
            wr_data <= vld_sr[RD_LAT-1] ? rd_data : '1;
        end
    end

endmodule

// File: rtl/act_loader.sv
// act_loader: streams activation words from a linear source memory into the
// activation buffer write port, one sub-block per actbuf_wr_req, waiting for
// a sblk_status rising edge between sub-blocks.
//   start/cfg_*          : job launch and configuration (latched in IDLE)
//   busy/done/err        : job status; err is sticky until the next start
//   mem_rd_*             : fixed-latency source read port
//   actbuf_wr_req/vld/data, sblk_status : activation buffer handshake
// Optional build macro ACT_LOADER_THROTTLE_EN adds cfg_burst/cfg_gap, which
// insert idle gaps between bursts of reads to create vld gaps downstream.
module act_loader
    import act_loader_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF,
    parameter int unsigned RD_LAT = RD_LAT_DEF
) (
    input  logic              clk_l,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] cfg_base,
    input  logic [CNT_W-1:0]  cfg_words,
    input  logic [CNT_W-1:0]  cfg_nsblk,
`ifdef ACT_LOADER_THROTTLE_EN
    input  logic [7:0]        cfg_burst,
    input  logic [7:0]        cfg_gap,
`endif
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    input  logic              actbuf_wr_req,
    output logic              actbuf_wr_vld,
    output logic [DATA_W-1:0] actbuf_wr_data,
    input  logic              sblk_status
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] offset_q, offset_d;
    logic [CNT_W-1:0]  words_q, words_d;
    logic [CNT_W-1:0]  nsblk_q, nsblk_d;
    logic [CNT_W-1:0]  issue_cnt_q, issue_cnt_d;
    logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
    logic [CNT_W-1:0]  sblk_cnt_q, sblk_cnt_d;
    logic              sblk_prev_q;
    logic              busy_d, done_d, err_d, rd_en_d;
    logic [ADDR_W-1:0] rd_addr_d;
    logic              sblk_rise;
    logic              issue_ok;

`ifdef ACT_LOADER_THROTTLE_EN
    logic [7:0] burst_q, burst_d;
    logic [7:0] gap_q, gap_d;
    logic [7:0] burst_cnt_q, burst_cnt_d;
    logic [7:0] gap_cnt_q, gap_cnt_d;

    // reads pause while a gap is being counted out
    assign issue_ok = (gap_cnt_q == 8'd0);
`else
    assign issue_ok = 1'b1;
`endif

    assign sblk_rise = sblk_status & ~sblk_prev_q;

    // state and registered outputs
    always_ff @(posedge clk_l) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            base_q      <= '0;
            offset_q    <= '0;
            words_q     <= '0;
            nsblk_q     <= '0;
            issue_cnt_q <= '0;
            wr_cnt_q    <= '0;
            sblk_cnt_q  <= '0;
            sblk_prev_q <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            mem_rd_en   <= 1'b0;
            mem_rd_addr <= '0;
`ifdef ACT_LOADER_THROTTLE_EN
            burst_q     <= '0;
            gap_q       <= '0;
            burst_cnt_q <= '0;
            gap_cnt_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            offset_q    <= offset_d;
            words_q     <= words_d;
            nsblk_q     <= nsblk_d;
            issue_cnt_q <= issue_cnt_d;
            wr_cnt_q    <= wr_cnt_d;
            sblk_cnt_q  <= sblk_cnt_d;
            sblk_prev_q <= sblk_status;
            busy        <= busy_d;
            done        <= done_d;
            err         <= err_d;
            mem_rd_en   <= rd_en_d;
            mem_rd_addr <= rd_addr_d;
`ifdef ACT_LOADER_THROTTLE_EN
            burst_q     <= burst_d;
            gap_q       <= gap_d;
            burst_cnt_q <= burst_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
`endif
        end
    end

    // next-state and output decode
    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        offset_d    = offset_q;
        words_d     = words_q;
        nsblk_d     = nsblk_q;
        issue_cnt_d = issue_cnt_q;
        wr_cnt_d    = wr_cnt_q;
        sblk_cnt_d  = sblk_cnt_q;
        busy_d      = busy;
        done_d      = 1'b0;
        err_d       = err;
        rd_en_d     = 1'b0;
        rd_addr_d   = mem_rd_addr;
`ifdef ACT_LOADER_THROTTLE_EN
        burst_d     = burst_q;
        gap_d       = gap_q;
        burst_cnt_d = burst_cnt_q;
        gap_cnt_d   = gap_cnt_q;
`endif

        if (actbuf_wr_vld) begin
            wr_cnt_d = wr_cnt_q + CNT_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    base_d      = cfg_base;
                    words_d     = cfg_words;
                    nsblk_d     = cfg_nsblk;
                    offset_d    = '0;
                    issue_cnt_d = '0;
                    wr_cnt_d    = '0;
                    sblk_cnt_d  = '0;
                    err_d       = 1'b0;
`ifdef ACT_LOADER_THROTTLE_EN
                    burst_d     = cfg_burst;
                    gap_d       = cfg_gap;
`endif
                    // an empty job completes immediately without touching memory
                    if (cfg_words == '0 || cfg_nsblk == '0) begin
                        done_d = 1'b1;
                        busy_d = 1'b0;
                    end else begin
                        busy_d  = 1'b1;
                        state_d = WAIT_REQ;
                    end
                end
            end

            WAIT_REQ: begin
                issue_cnt_d = '0;
                wr_cnt_d    = '0;
`ifdef ACT_LOADER_THROTTLE_EN
                burst_cnt_d = '0;
                gap_cnt_d   = '0;
`endif
                if (actbuf_wr_req) begin
                    state_d = ISSUE;
                end
            end

            ISSUE: begin
                if (sblk_rise) begin
                    err_d = 1'b1;
                end
                if (issue_ok) begin
                    rd_en_d     = 1'b1;
                    rd_addr_d   = base_q + offset_q;
                    offset_d    = offset_q + ADDR_W'(1);
                    issue_cnt_d = issue_cnt_q + CNT_W'(1);
                    if (issue_cnt_q + CNT_W'(1) == words_q) begin
                        state_d = DRAIN;
                    end
                end
`ifdef ACT_LOADER_THROTTLE_EN
                // count out a gap, or arm one after every cfg_burst reads
                if (!issue_ok) begin
                    gap_cnt_d = gap_cnt_q - 8'd1;
                end else if (burst_q != 8'd0 && gap_q != 8'd0) begin
                    if (burst_cnt_q + 8'd1 == burst_q) begin
                        burst_cnt_d = '0;
                        gap_cnt_d   = gap_q;
                    end else begin
                        burst_cnt_d = burst_cnt_q + 8'd1;
                    end
                end
`endif
            end

            DRAIN: begin
                if (sblk_rise) begin
                    err_d = 1'b1;
                end
                if (actbuf_wr_vld && (wr_cnt_q + CNT_W'(1) == words_q)) begin
                    wr_cnt_d = '0;
                    state_d  = WAIT_DONE;
                end
            end

            WAIT_DONE: begin
                if (sblk_rise) begin
                    sblk_cnt_d = sblk_cnt_q + CNT_W'(1);
                    if (sblk_cnt_q + CNT_W'(1) == nsblk_q) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        state_d = WAIT_REQ;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    act_loader_rdpipe #(
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT)
    ) u_rdpipe (
        .clk_l   (clk_l),
        .rst_n   (rst_n),
        .rd_en   (mem_rd_en),
        .rd_data (mem_rd_data),
        .wr_vld  (actbuf_wr_vld),
        .wr_data (actbuf_wr_data)
    );

endmodule

// File: doc/act_loader.md
Name: act_loader

Overview:
- Upstream feeder for ftdl_top's activation buffer write port. It drives actbuf_wr_data and actbuf_wr_vld, and consumes actbuf_wr_req and sblk_status.
- Fetches activation words from a linear source memory (on-chip ROM/URAM staging) through a fixed-latency read port.
- Streams one sub-block's worth of words per actbuf_wr_req, then waits for sblk_status before starting the next sub-block.
- Replaces the bench-side activation driver in system-level runs; runs in the clk_l domain.

Parameters:
- DATA_W, 32, write word width; equals 2*ACTBUF_DATA_LEN.
- ADDR_W, 16, source memory word-address width.
- CNT_W, 12, width of the per-sub-block word count and of the sub-block count.
- RD_LAT, 2, source memory read latency in cycles, 1..4.

Ports:
- clk_l  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  one-cycle pulse; latches cfg_* when IDLE.
- cfg_base  in  ADDR_W  first source word address.
- cfg_words  in  CNT_W  words per sub-block.
- cfg_nsblk  in  CNT_W  number of sub-blocks.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse after the last sub-block's sblk_status.
- err  out  1  sticky protocol error; cleared by start.
- mem_rd_en  out  1  source read strobe.
- mem_rd_addr  out  ADDR_W  source read address.
- mem_rd_data  in  DATA_W  valid RD_LAT cycles after mem_rd_en.
- actbuf_wr_req  in  1  level; ftdl_top ready for a sub-block fill.
- actbuf_wr_vld  out  1  write data valid.
- actbuf_wr_data  out  DATA_W  write data.
- sblk_status  in  1  rising edge means sub-block computation finished.

Behaviour:
- Reset state: all outputs 0, except actbuf_wr_data = all-ones. FSM in IDLE. Counters 0, address 0.
- States: IDLE, WAIT_REQ, ISSUE, DRAIN, WAIT_DONE.
- IDLE:
  - On start, latch cfg_*, clear err, set busy.
  - If cfg_words==0 or cfg_nsblk==0: pulse done next cycle, no reads or writes, busy drops with done.
  - Otherwise go to WAIT_REQ.
- start is ignored when not in IDLE.
- WAIT_REQ: when actbuf_wr_req==1, go to ISSUE.
- ISSUE:
  - Assert mem_rd_en every cycle with mem_rd_addr = base + running offset. The offset is carried across sub-blocks and wraps modulo 2^ADDR_W.
  - After cfg_words issues, go to DRAIN.
- Read pipeline: an RD_LAT-deep valid shift register tracks reads in flight.
  - actbuf_wr_vld = pipeline output. actbuf_wr_data = mem_rd_data, registered, for one more cycle of latency.
  - Read-to-write latency is RD_LAT+1 cycles.
  - When actbuf_wr_vld=0, actbuf_wr_data = all-ones.
- Write count: exactly cfg_words consecutive vld cycles per sub-block. There is no backpressure once issuing has started.
- DRAIN: when the last word has been written, go to WAIT_DONE.
- WAIT_DONE:
  - On a sblk_status rising edge (registered prev-value compare), increment the sub-block counter.
  - If it was the last sub-block: pulse done, drop busy, go to IDLE. Otherwise go to WAIT_REQ.
- A sblk_status rising edge in ISSUE or DRAIN sets err and is otherwise ignored.
- A sblk_status that is already high on entry to WAIT_DONE does not count. Only an edge counts.
- actbuf_wr_req dropping during ISSUE or DRAIN has no effect. The fill completes.
- Counters are CNT_W bits wide. cfg_words = 2^CNT_W-1 is legal.
- Reset mid-operation returns to the reset state on the next clk_l edge. Reads in flight are discarded and no vld is asserted after reset.

Optional Feature:
- Macro: ACT_LOADER_THROTTLE_EN.
- When defined:
  - Adds inputs cfg_burst and cfg_gap, each 8 bits, latched on start.
  - In ISSUE, after every cfg_burst reads, mem_rd_en is held low for cfg_gap cycles before issuing resumes. This yields idle gaps on actbuf_wr_vld, used to stress ftdl_top's tolerance of vld gaps.
  - cfg_burst==0 or cfg_gap==0 disables throttling.
- When undefined: the ports are absent and ISSUE is gap-free.

Decomposition:
- Package act_loader_pkg:
  - State enum (IDLE, WAIT_REQ, ISSUE, DRAIN, WAIT_DONE).
  - Idle data constant (all-ones).
  - Default widths; DATA_W default is derived from ACTBUF_DATA_LEN.
- One natural sub-module, act_loader_rdpipe: the RD_LAT valid shift register plus the output data register, with synchronous clear on reset.

Test Plan:
- base=0x0000, words=27, nsblk=2, RD_LAT=2, req high, sblk_status edge 20 cycles after each fill:
  - 27 vld words per fill, addresses 0..26 then 27..53.
  - First vld 3 cycles after first mem_rd_en.
  - done pulses once, after the 2nd edge.
- words=0, nsblk=5, start: done pulse the next cycle, zero mem_rd_en, zero vld, err=0.
- base=0xFFF0, words=32, nsblk=1: read addresses 0xFFF0..0xFFFF then 0x0000..0x000F; data order matches the memory model.
- sblk_status pulse during ISSUE (word 10 of 120): err=1, all 120 words still written, and the loader waits for a fresh edge before done.
- rst_n low for 1 cycle at word 15 of 27: on the next cycle vld=0, data=all-ones, busy=0; no further vld; a new start runs cleanly.
- With ACT_LOADER_THROTTLE_EN, burst=4, gap=5, words=27: vld pattern is 4 on / 5 off, ending with a final group of 3; 27 words total.
